// File: rtl/axi_periph_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_periph_slave
//  Description : AXI4-Lite register-file slave. NREGS 32-bit registers start
//                at byte address ADDR_BASE. The read and write channels are
//                handled by independent two-state FSMs. Register 0 is exported
//                on CtrlReg for use by the surrounding fabric.
//  Build macro : AXI_SLV_ERRRESP_EN -- when defined, accesses outside the
//                register window respond SLVERR (2'b10); otherwise OKAY.
//                Out-of-range writes are dropped and out-of-range reads
//                return zero in both builds.
//  Ports       : Clk, Rst (synchronous, active-high)
//                S_AW*  write address channel   S_W* write data channel
//                S_B*   write response channel  S_AR* read address channel
//                S_R*   read data channel       CtrlReg live copy of reg 0
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_periph_slave #(
  parameter logic [31:0] ADDR_BASE = 32'h0001_0000,
  parameter int          NREGS     = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  // Write address
  input  logic [31:0] S_AWADDR,
  input  logic        S_AWVALID,
  output logic        S_AWREADY,
  // Write data
  input  logic [31:0] S_WDATA,
  input  logic [3:0]  S_WSTRB,
  input  logic        S_WVALID,
  output logic        S_WREADY,
  // Write response
  output logic [1:0]  S_BRESP,
  output logic        S_BVALID,
  input  logic        S_BREADY,
  // Read address
  input  logic [31:0] S_ARADDR,
  input  logic        S_ARVALID,
  output logic        S_ARREADY,
  // Read data
  output logic [31:0] S_RDATA,
  output logic [1:0]  S_RRESP,
  output logic        S_RVALID,
  input  logic        S_RREADY,
  // Fabric-side copy of register 0
  output logic [31:0] CtrlReg
);

  localparam int          IDX_W       = $clog2(NREGS);
  localparam logic [31:0] c_spanBytes = 32'(NREGS * 4);
  localparam logic [1:0]  c_respOkay  = 2'b00;
`ifdef AXI_SLV_ERRRESP_EN
  localparam logic [1:0]  c_respRange = 2'b10;
`else
  localparam logic [1:0]  c_respRange = 2'b00;
`endif

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wrState_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rdState_t;

  wrState_t r_wrState, w_wrNext;
  rdState_t r_rdState, w_rdNext;

  logic [31:0] r_regs [NREGS];
  logic [1:0]  r_bResp;
  logic [31:0] r_rData;
  logic [1:0]  r_rResp;

  // --------------------------------------------------------------------------
  // Address decode. The subtraction wraps for addresses below the base, so
  // the explicit lower-bound compare is required alongside the span check.
  // --------------------------------------------------------------------------
  logic [31:0]      w_wrOffset, w_rdOffset;
  logic             w_wrInRange, w_rdInRange;
  logic [IDX_W-1:0] w_wrIdx, w_rdIdx;

  assign w_wrOffset  = S_AWADDR - ADDR_BASE;
  assign w_rdOffset  = S_ARADDR - ADDR_BASE;
  assign w_wrInRange = (S_AWADDR >= ADDR_BASE) && (w_wrOffset < c_spanBytes);
  assign w_rdInRange = (S_ARADDR >= ADDR_BASE) && (w_rdOffset < c_spanBytes);
  assign w_wrIdx     = IDX_W'(w_wrOffset >> 2);
  assign w_rdIdx     = IDX_W'(w_rdOffset >> 2);

  logic w_wrHs, w_rdHs;
  assign w_wrHs = S_AWVALID & S_AWREADY & S_WVALID & S_WREADY;
  assign w_rdHs = S_ARVALID & S_ARREADY;

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wrState <= W_IDLE;
    end else begin
      r_wrState <= w_wrNext;
    end
  end

  // Address and data are only accepted together, so a master that presents
  // one channel early simply waits until the other arrives.
  always_comb begin
    w_wrNext  = r_wrState;
    S_AWREADY = 1'b0;
    S_WREADY  = 1'b0;
    S_BVALID  = 1'b0;
    case (r_wrState)
      W_IDLE: begin
        if (!Rst && S_AWVALID && S_WVALID) begin
          S_AWREADY = 1'b1;
          S_WREADY  = 1'b1;
          w_wrNext  = W_RESP;
        end
      end
      W_RESP: begin
        S_BVALID = !Rst;
        if (S_BREADY) begin
          w_wrNext = W_IDLE;
        end
      end
      default: w_wrNext = W_IDLE;
    endcase
  end

  // Register file and write response. Reads below sample r_regs before this
  // block's non-blocking update, so a same-cycle read sees the old value.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_bResp <= 2'b00;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= 32'h0;
      end
    end else if (w_wrHs) begin
      r_bResp <= w_wrInRange ? c_respOkay : c_respRange;
      if (w_wrInRange) begin
        for (int b = 0; b < 4; b++) begin
          if (S_WSTRB[b]) begin
            r_regs[w_wrIdx][8*b +: 8] <= S_WDATA[8*b +: 8];
          end
        end
      end
    end
  end

  assign S_BRESP = r_bResp;
  assign CtrlReg = r_regs[0];

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rdState <= R_IDLE;
    end else begin
      r_rdState <= w_rdNext;
    end
  end

  always_comb begin
    w_rdNext  = r_rdState;
    S_ARREADY = 1'b0;
    S_RVALID  = 1'b0;
    case (r_rdState)
      R_IDLE: begin
        S_ARREADY = !Rst;
        if (!Rst && S_ARVALID) begin
          w_rdNext = R_DATA;
        end
      end
      R_DATA: begin
        S_RVALID = !Rst;
        if (S_RREADY) begin
          w_rdNext = R_IDLE;
        end
      end
      default: w_rdNext = R_IDLE;
    endcase
  end

  // Read data is captured once at the address handshake and held until the
  // data handshake, independent of later register writes.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rData <= 32'h0;
      r_rResp <= 2'b00;
    end else if (w_rdHs) begin
      r_rData <= w_rdInRange ? r_regs[w_rdIdx] : 32'h0;
      r_rResp <= w_rdInRange ? c_respOkay : c_respRange;
    end
  end

  assign S_RDATA = r_rData;
  assign S_RRESP = r_rResp;

endmodule
`default_nettype wire

// File: tb/tb_axi_periph_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_periph_slave
//  Description : Self-checking bench for axi_periph_slave. Directed scenarios
//                followed by random reads/writes compared against a simple
//                array model of the register window.
//  Build macro : AXI_SLV_ERRRESP_EN changes the expected out-of-range response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_periph_slave;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          NREGS = 16;
`ifdef AXI_SLV_ERRRESP_EN
  localparam logic [31:0] ERR_RESP = 32'h2;
`else
  localparam logic [31:0] ERR_RESP = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awAddr = '0;
  logic        awValid = 1'b0;
  logic        awReady;
  logic [31:0] wData = '0;
  logic [3:0]  wStrb = '0;
  logic        wValid = 1'b0;
  logic        wReady;
  logic [1:0]  bResp;
  logic        bValid;
  logic        bReady = 1'b0;
  logic [31:0] arAddr = '0;
  logic        arValid = 1'b0;
  logic        arReady;
  logic [31:0] rData;
  logic [1:0]  rResp;
  logic        rValid;
  logic        rReady = 1'b0;
  logic [31:0] ctrlReg;

  int errCount = 0;
  int checkCount = 0;

  logic [31:0] model [NREGS];

  always #5 clk = ~clk;

  axi_periph_slave #(.ADDR_BASE(BASE), .NREGS(NREGS)) dut (
    .Clk(clk), .Rst(rst),
    .S_AWADDR(awAddr), .S_AWVALID(awValid), .S_AWREADY(awReady),
    .S_WDATA(wData), .S_WSTRB(wStrb), .S_WVALID(wValid), .S_WREADY(wReady),
    .S_BRESP(bResp), .S_BVALID(bValid), .S_BREADY(bReady),
    .S_ARADDR(arAddr), .S_ARVALID(arValid), .S_ARREADY(arReady),
    .S_RDATA(rData), .S_RRESP(rResp), .S_RVALID(rValid), .S_RREADY(rReady),
    .CtrlReg(ctrlReg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit inWindow(input logic [31:0] addr);
    return (addr >= BASE) && ((addr - BASE) < NREGS * 4);
  endfunction

  function automatic int regIndex(input logic [31:0] addr);
    return int'((addr - BASE) / 4);
  endfunction

  function automatic logic [31:0] expResp(input logic [31:0] addr);
    return inWindow(addr) ? 32'h0 : ERR_RESP;
  endfunction

  task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (inWindow(addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[regIndex(addr)][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] addr);
    return inWindow(addr) ? model[regIndex(addr)] : 32'h0;
  endfunction

  // Full write transaction; BREADY is withheld for bDelay cycles.
  task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int bDelay);
    @(posedge clk); #1;
    awAddr = addr; wData = data; wStrb = strb;
    awValid = 1'b1; wValid = 1'b1; bReady = 1'b0;
    @(negedge clk);
    check("awready", {31'b0, awReady}, 32'h1);
    check("wready", {31'b0, wReady}, 32'h1);
    @(posedge clk); #1;
    awValid = 1'b0; wValid = 1'b0;
    modelWrite(addr, data, strb);
    @(negedge clk);
    check("bvalid", {31'b0, bValid}, 32'h1);
    check("bresp", {30'b0, bResp}, expResp(addr));
    check("ctrlreg", ctrlReg, model[0]);
    for (int k = 0; k < bDelay; k++) begin
      @(posedge clk); @(negedge clk);
      check("bvalid_hold", {31'b0, bValid}, 32'h1);
      check("awready_resp", {31'b0, awReady}, 32'h0);
    end
    @(posedge clk); #1 bReady = 1'b1;
    @(posedge clk); #1 bReady = 1'b0;
    @(negedge clk);
    check("bvalid_done", {31'b0, bValid}, 32'h0);
  endtask

  // Full read transaction; RREADY is withheld for rDelay cycles.
  task automatic axiRead(input logic [31:0] addr, input int rDelay);
    logic [31:0] exp;
    @(posedge clk); #1;
    arAddr = addr; arValid = 1'b1; rReady = 1'b0;
    @(negedge clk);
    check("arready", {31'b0, arReady}, 32'h1);
    exp = modelRead(addr);
    @(posedge clk); #1;
    arValid = 1'b0;
    @(negedge clk);
    check("rvalid", {31'b0, rValid}, 32'h1);
    check("rdata", rData, exp);
    check("rresp", {30'b0, rResp}, expResp(addr));
    for (int k = 0; k < rDelay; k++) begin
      @(posedge clk); @(negedge clk);
      check("rvalid_hold", {31'b0, rValid}, 32'h1);
      check("rdata_hold", rData, exp);
      check("rresp_hold", {30'b0, rResp}, expResp(addr));
      check("arready_busy", {31'b0, arReady}, 32'h0);
    end
    @(posedge clk); #1 rReady = 1'b1;
    @(posedge clk); #1 rReady = 1'b0;
    @(negedge clk);
    check("rvalid_done", {31'b0, rValid}, 32'h0);
    check("arready_back", {31'b0, arReady}, 32'h1);
  endtask

  task automatic checkAllRegs(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      axiRead(BASE + 32'(i * 4), 0);
    end
    check(tag, ctrlReg, model[0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] addr, data, oldVal;
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", {31'b0, awReady}, 32'h0);
    check("rst_arready", {31'b0, arReady}, 32'h0);
    check("rst_bvalid", {31'b0, bValid}, 32'h0);
    check("rst_rvalid", {31'b0, rValid}, 32'h0);
    check("rst_rdata", rData, 32'h0);
    check("rst_ctrl", ctrlReg, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("idle_arready", {31'b0, arReady}, 32'h1);

    // Basic write/read, partial strobe
    axiWrite(32'h0001_0004, 32'hDEADBEEF, 4'hF, 0);
    axiRead(32'h0001_0004, 0);
    axiWrite(32'h0001_0004, 32'h0000_1122, 4'b0011, 1);
    axiRead(32'h0001_0004, 0);
    check("strb_merge", model[1], 32'hDEAD1122);

    // Address without data is not accepted alone
    @(posedge clk); #1;
    awAddr = 32'h0001_0008; awValid = 1'b1; wData = 32'hA5A5_0001; wStrb = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("aw_alone", {31'b0, awReady}, 32'h0);
      @(posedge clk);
    end
    #1 wValid = 1'b1;
    @(negedge clk);
    check("aw_join", {31'b0, awReady}, 32'h1);
    check("w_join", {31'b0, wReady}, 32'h1);
    @(posedge clk); #1;
    awValid = 1'b0; wValid = 1'b0; bReady = 1'b1;
    modelWrite(32'h0001_0008, 32'hA5A5_0001, 4'hF);
    @(posedge clk); #1 bReady = 1'b0;
    axiRead(32'h0001_0008, 0);

    // Out-of-range accesses
    axiRead(32'h0001_0040, 3);
    axiWrite(32'h0001_0040, 32'hFFFF_FFFF, 4'hF, 0);
    axiWrite(32'h0000_FFFC, 32'hFFFF_FFFF, 4'hF, 0);
    checkAllRegs("oor_ctrl");

    // Same-cycle write and read of register 0
    oldVal = model[0];
    @(posedge clk); #1;
    awAddr = BASE; wData = 32'h5; wStrb = 4'hF; awValid = 1'b1; wValid = 1'b1;
    arAddr = BASE; arValid = 1'b1; bReady = 1'b1; rReady = 1'b1;
    @(posedge clk); #1;
    awValid = 1'b0; wValid = 1'b0; arValid = 1'b0;
    modelWrite(BASE, 32'h5, 4'hF);
    @(negedge clk);
    check("same_rvalid", {31'b0, rValid}, 32'h1);
    check("same_rdata", rData, oldVal);
    check("same_ctrl", ctrlReg, 32'h5);
    check("same_bvalid", {31'b0, bValid}, 32'h1);
    @(posedge clk); #1 bReady = 1'b0; rReady = 1'b0;
    @(negedge clk);
    check("same_idle", {31'b0, rValid | bValid}, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 7) addr = BASE + 32'($urandom_range(0, NREGS - 1) * 4) + 32'($urandom_range(0, 3));
      else if (sel == 7) addr = BASE + 32'(NREGS * 4) + 32'($urandom_range(0, 255));
      else if (sel == 8) addr = BASE - 32'h1 - 32'($urandom_range(0, 255));
      else addr = $urandom;
      data = $urandom;
      if ($urandom_range(0, 1) == 0)
        axiWrite(addr, data, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      else
        axiRead(addr, int'($urandom_range(0, 2)));
    end
    checkAllRegs("rand_ctrl");

    // Reset while a write response is pending
    axiWrite(32'h0001_000C, 32'h1234_5678, 4'hF, 0);
    @(posedge clk); #1;
    awAddr = 32'h0001_0010; wData = 32'hCAFE_F00D; wStrb = 4'hF;
    awValid = 1'b1; wValid = 1'b1; bReady = 1'b0;
    @(posedge clk); #1;
    awValid = 1'b0; wValid = 1'b0;
    @(negedge clk);
    check("pre_rst_bvalid", {31'b0, bValid}, 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_mid_bvalid", {31'b0, bValid}, 32'h0);
    check("rst_mid_arready", {31'b0, arReady}, 32'h0);
    check("rst_mid_ctrl", ctrlReg, 32'h0);
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    @(posedge clk); #1 rst = 1'b0;
    checkAllRegs("post_rst_ctrl");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_periph_slave.md
AXI_PERIPH_SLAVE -- requirements
Module: axi_periph_slave

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h10000, byte address of register 0.
REQ-002 SHALL have parameter NREGS, default 16, number of 32-bit registers (power of two, 2..256).
REQ-003 SHALL have port Clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port Rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have ports S_AWADDR in 32, S_AWVALID in 1, S_AWREADY out 1  (AXI4-Lite write address).
REQ-006 SHALL have ports S_WDATA in 32, S_WSTRB in 4, S_WVALID in 1, S_WREADY out 1  (write data).
REQ-007 SHALL have ports S_BRESP out 2, S_BVALID out 1, S_BREADY in 1  (write response).
REQ-008 SHALL have ports S_ARADDR in 32, S_ARVALID in 1, S_ARREADY out 1  (read address).
REQ-009 SHALL have ports S_RDATA out 32, S_RRESP out 2, S_RVALID out 1, S_RREADY in 1  (read data).
REQ-010 SHALL have port CtrlReg  out  32  live copy of register 0 for fabric use.

Function
REQ-011 Decode: offset = addr - ADDR_BASE; in-range iff addr >= ADDR_BASE and offset < NREGS*4; index = offset[log2(NREGS)+1:2]; addr[1:0] ignored.
REQ-012 Write FSM states: W_IDLE, W_RESP.
REQ-013 In W_IDLE, S_AWREADY and S_WREADY SHALL both be 1 only when S_AWVALID and S_WVALID are both 1; no channel is accepted alone.
REQ-014 Write handshake cycle: for in-range address, byte i of the register updates at that edge iff S_WSTRB[i]=1; FSM goes to W_RESP.
REQ-015 W_RESP: S_BVALID=1 with S_BRESP stable; S_AWREADY=S_WREADY=0; leaves to W_IDLE on the edge where S_BREADY=1.
REQ-016 Minimum write spacing SHALL be 2 cycles; a new write SHALL be accepted in the first W_IDLE cycle after the B handshake.
REQ-017 Read FSM states: R_IDLE (S_ARREADY=1), R_DATA (S_ARREADY=0, S_RVALID=1).
REQ-018 On S_ARVALID&S_ARREADY, S_RDATA/S_RRESP SHALL be registered and S_RVALID=1 on the next cycle (latency 1).
REQ-019 S_RDATA/S_RRESP SHALL hold stable until S_RVALID&S_RREADY; FSM then returns to R_IDLE (next read accepted the following cycle).
REQ-020 Read and write FSMs SHALL be independent; both handshakes may occur in the same cycle.
REQ-021 Read and write to the same register in the same cycle: read returns the pre-write value.
REQ-022 CtrlReg SHALL reflect register 0 one cycle after the write handshake.
REQ-023 Response values SHALL be OKAY=2'b00 except as in REQ-030.

Reset
REQ-024 While Rst=1: all registers, S_RDATA, S_BRESP, S_RRESP = 0; S_BVALID, S_RVALID, S_AWREADY, S_WREADY, S_ARREADY = 0.
REQ-025 After the first edge with Rst=0, both FSMs SHALL be in IDLE (S_ARREADY=1).
REQ-026 Rst asserted mid-transaction SHALL abandon it: pending BVALID/RVALID drop at that edge, no partial write retained.

Configuration
REQ-027 Macro AXI_SLV_ERRRESP_EN selects out-of-range error reporting.
REQ-028 Out-of-range writes SHALL never modify any register, in either build.
REQ-029 Out-of-range reads SHALL return S_RDATA=0, in either build.
REQ-030 With AXI_SLV_ERRRESP_EN defined, out-of-range accesses SHALL respond SLVERR (2'b10); without it, OKAY (2'b00).

Verification
REQ-031 Write 0xDEADBEEF to 0x10004, STRB=4'hF, BREADY=1 -> BVALID 1 cycle after handshake, BRESP=00; read 0x10004 -> RDATA=0xDEADBEEF, RVALID 1 cycle after AR handshake.
REQ-032 Reg1=0xDEADBEEF, write 0x00001122 STRB=4'b0011 -> read returns 0xDEAD1122.
REQ-033 AWVALID=1 with WVALID=0 for 5 cycles -> AWREADY stays 0; WVALID rises -> both READY=1 same cycle.
REQ-034 Read 0x10040 (NREGS=16), RREADY held 0 for 3 cycles -> RVALID/RDATA=0 stable; RRESP=10 if macro defined, else 00.
REQ-035 Same-cycle write 0x5 and read of 0x10000 (old 0x0) -> RDATA=0x0, CtrlReg=0x5 next cycle.
REQ-036 Rst=1 while BVALID=1 awaiting BREADY -> BVALID=0, all registers 0 after the edge.
